shift_deserializer: RTL and testbench

Serial-in, parallel-out receiver. It is the receiving end of the MSB-first serial stream produced by the team's parallel-load shifter. Bits are sampled on qualified clock edges and assembled into NBits-wide words. Each completed word is presented on a holding register with a valid/ready handshake. A sticky overrun flag reports words lost because the consumer stalled.

---
 rtl/shift_deserializer.sv | 85 ++++++++
 tb/tb_shift_deserializer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// MSB-first serial-in, parallel-out receiver with a valid/ready holding register and a sticky overrun flag.
// A word becomes visible the edge its last bit is sampled. If the consumer stalls, new words are dropped and flagged.
module shift_deserializer #(
  parameter int NBits = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             In,
  input  logic             InValid,
  input  logic             Sync,
  output logic [NBits-1:0] Data,
  output logic             Valid,
  input  logic             Ready,
  output logic             Overrun,
  input  logic             ClearOverrun
);

  localparam int CW = (NBits > 2) ? $clog2(NBits) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBits - 1);

  logic [NBits-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBits-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [NBits-1:0] word;

  assign word = {shift_q[NBits-2:0], In};

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (valid_q && Ready) valid_d = 1'b0;
    if (ClearOverrun)     ovr_d   = 1'b0;

    if (Sync) begin
      // A restart discards the partial word; a bit arriving with it starts the new one.
      if (InValid) begin
        shift_d = {{(NBits-1){1'b0}}, In};
        cnt_d   = CW'(1);
      end else begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (InValid) begin
      shift_d = word;
      if (cnt_q == LAST) begin
        cnt_d = '0;
        if (!valid_q || Ready) begin
          data_d  = word;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Data    = data_q;
  assign Valid   = valid_q;
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer with NBits=8.
module tb_shift_deserializer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       In = 1'b0;
  logic       InValid = 1'b0;
  logic       Sync = 1'b0;
  logic       Ready = 1'b0;
  logic       ClearOverrun = 1'b0;
  logic [7:0] Data;
  logic       Valid;
  logic       Overrun;

  int checks = 0;
  int failures = 0;

  shift_deserializer #(.NBits(8)) dut (
    .Clock(Clock), .Reset(Reset), .In(In), .InValid(InValid), .Sync(Sync),
    .Data(Data), .Valid(Valid), .Ready(Ready), .Overrun(Overrun),
    .ClearOverrun(ClearOverrun)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    InValid = 1'b0;
    In = 1'b0;
    tick();
  endtask

  // Sends bits w[hi] down to w[lo], one qualified edge each.
  task automatic send_range(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      In = w[i];
      InValid = 1'b1;
      tick();
    end
    InValid = 1'b0;
    In = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_data", Data, 8'h00);
    chk("rst_valid", Valid, 1'b0);
    chk("rst_ovr", Overrun, 1'b0);
    tick();
    Reset = 1'b0;
    tick();

    // Basic word
    Ready = 1'b1;
    send_range(8'hA5, 7, 1);
    chk("basic_pre_valid", Valid, 1'b0);
    send_range(8'hA5, 0, 0);
    chk("basic_valid", Valid, 1'b1);
    chk("basic_data", Data, 8'hA5);
    idle();
    chk("basic_accept_valid", Valid, 1'b0);
    chk("basic_hold_data", Data, 8'hA5);

    // Gapped input
    send_range(8'h3C, 7, 5);
    idle(); idle(); idle();
    send_range(8'h3C, 4, 1);
    chk("gap_pre_valid", Valid, 1'b0);
    send_range(8'h3C, 0, 0);
    chk("gap_valid", Valid, 1'b1);
    chk("gap_data", Data, 8'h3C);
    idle();

    // Overrun
    Ready = 1'b0;
    send_range(8'h11, 7, 0);
    chk("ovr_first_valid", Valid, 1'b1);
    chk("ovr_first_flag", Overrun, 1'b0);
    send_range(8'h22, 7, 0);
    chk("ovr_data", Data, 8'h11);
    chk("ovr_valid", Valid, 1'b1);
    chk("ovr_flag", Overrun, 1'b1);
    Ready = 1'b1;
    idle();
    chk("ovr_accept_valid", Valid, 1'b0);
    chk("ovr_sticky", Overrun, 1'b1);
    Ready = 1'b0;
    ClearOverrun = 1'b1;
    idle();
    ClearOverrun = 1'b0;
    chk("ovr_cleared", Overrun, 1'b0);

    // Simultaneous handshake and completion
    send_range(8'h11, 7, 0);
    chk("sim_first_data", Data, 8'h11);
    send_range(8'h22, 7, 1);
    chk("sim_stable_data", Data, 8'h11);
    Ready = 1'b1;
    send_range(8'h22, 0, 0);
    chk("sim_data", Data, 8'h22);
    chk("sim_valid", Valid, 1'b1);
    chk("sim_ovr", Overrun, 1'b0);
    idle();
    chk("sim_accept_valid", Valid, 1'b0);

    // Sync mid-word
    send_range(8'hFF, 7, 3);
    Sync = 1'b1; In = 1'b1; InValid = 1'b1;
    tick();
    Sync = 1'b0;
    chk("sync_no_word", Valid, 1'b0);
    send_range(8'h2A, 6, 1);
    chk("sync_pre_valid", Valid, 1'b0);
    send_range(8'h2A, 0, 0);
    chk("sync_valid", Valid, 1'b1);
    chk("sync_data", Data, 8'hAA);
    idle();

    // Sync on the would-be last bit never completes a word
    send_range(8'hFF, 7, 1);
    Sync = 1'b1; In = 1'b1; InValid = 1'b1;
    tick();
    Sync = 1'b0;
    chk("sync_last_no_word", Valid, 1'b0);
    chk("sync_last_data", Data, 8'hAA);
    send_range(8'h5A, 6, 0);
    chk("sync_last_valid", Valid, 1'b1);
    chk("sync_last_new", Data, 8'hDA);
    idle();

    // Reset mid-word, with a word pending
    Ready = 1'b0;
    send_range(8'h5A, 7, 0);
    chk("pre_rst_valid", Valid, 1'b1);
    send_range(8'hF0, 7, 4);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_data", Data, 8'h00);
    chk("mid_rst_valid", Valid, 1'b0);
    chk("mid_rst_ovr", Overrun, 1'b0);
    tick();
    chk("held_rst_data", Data, 8'h00);
    Reset = 1'b0;
    Ready = 1'b1;
    idle();
    send_range(8'h81, 7, 0);
    chk("post_rst_valid", Valid, 1'b1);
    chk("post_rst_data", Data, 8'h81);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
